hs_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready downstream channel among N_REQ upstream valid/ready requesters. It holds one registered output slot (one-entry buffer), so the output is fully registered and sustains one beat per cycle. It sits in the SoC handshake fabric, in front of any single-consumer stage that several masters must feed.

---
 rtl/hs_rr_arbiter_pkg.sv | 13 +
 rtl/hs_rr_arbiter_pick.sv | 31 +++
 rtl/hs_rr_arbiter.sv | 112 +++++++++++
 tb/tb_hs_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hs_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
package hs_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module hs_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      j = (32'(ptr) + off) % N_REQ;
      if (!any && req[j] && mask[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter with a one-entry registered output slot.
// Packet locking on req_last_i is enabled by defining HS_ARB_PKT_LOCK_EN.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned ID_W   = id_width(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
  input  logic [N_REQ-1:0]              req_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [ID_W-1:0]               out_id_o,
  output logic                          out_last_o
);

  arb_state_e       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  lock_id;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             slot_free;
  logic             push;
  logic             win_last;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] i);
    return (32'(i) >= N_REQ - 1) ? '0 : ID_W'(32'(i) + 1);
  endfunction

  always_comb begin
    mask = '1;
    if (state == LOCK) begin
      mask          = '0;
      mask[lock_id] = 1'b1;
    end
  end

  hs_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req_valid_i),
    .ptr   (ptr),
    .mask  (mask),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign slot_free   = !out_valid_o || out_ready_i;
  assign push        = pick_any && slot_free && !rst;
  assign req_ready_o = push ? pick_grant : '0;

`ifdef HS_ARB_PKT_LOCK_EN
  assign win_last = req_last_i[pick_idx];
`else
  // Without packet locking every beat is its own packet, so the FSM never leaves ARB.
  logic unused_last;
  assign unused_last = ^req_last_i;
  assign win_last    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      out_last_o  <= 1'b0;
      ptr         <= '0;
      lock_id     <= '0;
      state       <= ARB;
    end else begin
      if (push) begin
        out_valid_o <= 1'b1;
        out_data_o  <= req_data_i[pick_idx];
        out_id_o    <= pick_idx;
        out_last_o  <= win_last;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      case (state)
        ARB: begin
          if (push) begin
            if (win_last) begin
              ptr <= ptr_after(pick_idx);
            end else begin
              state   <= LOCK;
              lock_id <= pick_idx;
            end
          end
        end
        LOCK: begin
          if (push && win_last) begin
            state <= ARB;
            ptr   <= ptr_after(lock_id);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed scoreboard bench for hs_rr_arbiter (expectations follow HS_ARB_PKT_LOCK_EN).
module tb_hs_rr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned IDW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid_i = '0;
  logic [N-1:0]        req_ready_o;
  logic [N-1:0][W-1:0] req_data_i = '0;
  logic [N-1:0]        req_last_i = '0;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic [W-1:0]        out_data_o;
  logic [IDW-1:0]      out_id_o;
  logic                out_last_o;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;
  int stepno = 0;

  hs_rr_arbiter #(
    .N_REQ  (N),
    .DATA_W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pay(input int i, input int s);
    return {16'(i), 16'(s)};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic ordy, input logic [N-1:0] exp_rdy);
    beat_t b;
    int    w;
    @(posedge clk);
    #1;
    stepno++;
    req_valid_i = v;
    req_last_i  = l;
    out_ready_i = ordy;
    for (int i = 0; i < N; i++) req_data_i[i] = pay(i, stepno);
    @(negedge clk);
    chk({tag, ".ready"}, W'(req_ready_o), W'(exp_rdy));
    chk({tag, ".valid"}, W'(out_valid_o), W'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, ".data"}, out_data_o, sb[0].data);
      chk({tag, ".id"}, W'(out_id_o), W'(sb[0].id));
      chk({tag, ".last"}, W'(out_last_o), W'(sb[0].last));
      if (ordy) void'(sb.pop_front());
    end
    if (exp_rdy != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) w = i;
      b.data = pay(w, stepno);
      b.id   = IDW'(w);
`ifdef HS_ARB_PKT_LOCK_EN
      b.last = l[w];
`else
      b.last = 1'b1;
`endif
      sb.push_back(b);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    req_valid_i = v;
    req_last_i  = '0;
    out_ready_i = 1'b0;
    @(negedge clk);
    chk("rst.ready", W'(req_ready_o), '0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    req_valid_i = '0;
    sb.delete();
    @(negedge clk);
    chk("rst.valid", W'(out_valid_o), '0);
    chk("rst.data", out_data_o, '0);
    chk("rst.id", W'(out_id_o), '0);
    chk("rst.last", W'(out_last_o), '0);
  endtask

  initial begin
    do_reset(4'b1111);

    // all requesters streaming: strict rotation, no gaps
    step("rot0", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    step("rot1", 4'b1111, 4'b1111, 1'b1, 4'b0010);
    step("rot2", 4'b1111, 4'b1111, 1'b1, 4'b0100);
    step("rot3", 4'b1111, 4'b1111, 1'b1, 4'b1000);
    step("rot4", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    step("rot5", 4'b1111, 4'b1111, 1'b1, 4'b0010);
    step("rot6", 4'b1111, 4'b1111, 1'b1, 4'b0100);
    step("rot7", 4'b1111, 4'b1111, 1'b1, 4'b1000);

    // downstream stall with slot full, then push+pop in one cycle
    step("stall0", 4'b1111, 4'b1111, 1'b0, 4'b0000);
    step("stall1", 4'b1111, 4'b1111, 1'b0, 4'b0000);
    step("release", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    step("drain0", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step("drain1", 4'b0000, 4'b0000, 1'b1, 4'b0000);

`ifndef HS_ARB_PKT_LOCK_EN
    // last=0 beats are still arbitrated one by one
    step("alt0", 4'b1010, 4'b0000, 1'b1, 4'b0010);
    step("alt1", 4'b1010, 4'b0000, 1'b1, 4'b1000);
    step("alt2", 4'b1010, 4'b0000, 1'b1, 4'b0010);
    step("alt3", 4'b1010, 4'b0000, 1'b1, 4'b1000);
    step("hold", 4'b0000, 4'b0000, 1'b0, 4'b0000);
    do_reset(4'b1111);
    step("post_rst", 4'b1010, 4'b1111, 1'b1, 4'b0010);
    step("end0", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step("end1", 4'b0000, 4'b0000, 1'b1, 4'b0000);
`else
    step("seed", 4'b0010, 4'b1111, 1'b1, 4'b0010);
    // req 2 three-beat packet while req 0 keeps asking
    step("pkt0", 4'b0101, 4'b0000, 1'b1, 4'b0100);
    step("pkt1", 4'b0101, 4'b0000, 1'b1, 4'b0100);
    step("pkt2", 4'b0101, 4'b0100, 1'b1, 4'b0100);
    step("pkt3", 4'b0101, 4'b1111, 1'b1, 4'b0001);
    // locked requester goes idle mid-packet
    step("bub0", 4'b1011, 4'b0000, 1'b1, 4'b0010);
    step("bub1", 4'b1001, 4'b0000, 1'b1, 4'b0000);
    step("bub2", 4'b1001, 4'b0000, 1'b1, 4'b0000);
    step("bub3", 4'b1011, 4'b0000, 1'b1, 4'b0010);
    step("bub4", 4'b1011, 4'b0010, 1'b1, 4'b0010);
    step("bub5", 4'b1011, 4'b1111, 1'b1, 4'b1000);
    // reset while locked with a beat buffered
    step("lockrst", 4'b1000, 4'b0000, 1'b1, 4'b1000);
    do_reset(4'b1111);
    step("post_rst", 4'b1010, 4'b1111, 1'b1, 4'b0010);
    step("end0", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    step("end1", 4'b0000, 4'b0000, 1'b1, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
